serial_add_ctrl: RTL and testbench

Bit-serial addition controller that time-shares one external 1-bit full-adder slice to add two WIDTH-bit operands, one bit per clock, LSB first. It accepts an operation through a ready/start handshake. It presents LSB-first operand bits and a registered carry to the slice, collects the slice outputs, and returns a WIDTH-bit sum plus carry-out with a one-cycle done pulse. It sits between operand-producing logic and the full-adder slice, giving a small area-for-latency adder.

---
 rtl/serial_add_ctrl.sv | 115 +++++++++++
 tb/tb_serial_add_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller for an external 1-bit slice.
// Operands are fed LSB first, one bit per clock, with a registered carry.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_carry
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_s_sh;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic [WIDTH-1:0] w_s_next;

  // Slice sum enters at the MSB; shift form also covers WIDTH=1.
  assign w_s_next = (r_s_sh >> 1)
                  | (WIDTH'(fa_sum) << (WIDTH - 1));

  // Slice inputs come only from flops, gated to zero outside RUN.
  assign fa_a   = r_busy & r_a_sh[0];
  assign fa_b   = r_busy & r_b_sh[0];
  assign fa_cin = r_busy & r_c;

  assign ready = r_ready;
  assign busy  = r_busy;
  assign done  = r_done;
  assign sum   = r_sum;
  assign cout  = r_cout;

  // Control FSM with datapath shifting and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_s_sh  <= '0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_c     <= cin;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_s_sh <= w_s_next;
          r_c    <= fa_carry;
          r_a_sh <= r_a_sh >> 1;
          r_b_sh <= r_b_sh >> 1;
          r_cnt  <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_sum   <= w_s_next;
            r_cout  <= fa_carry;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed and random checks of serial_add_ctrl.
// Two instances: WIDTH=8 and WIDTH=1, each with a behavioural slice.
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic       rst_n;
  logic       start8, cin8;
  logic [7:0] a8, b8;
  logic       ready8, busy8, done8, cout8;
  logic [7:0] sum8;
  logic       fa8_a, fa8_b, fa8_cin, fa8_sum, fa8_carry;

  logic       start1, cin1;
  logic [0:0] a1, b1;
  logic       ready1, busy1, done1, cout1;
  logic [0:0] sum1;
  logic       fa1_a, fa1_b, fa1_cin, fa1_sum, fa1_carry;

  assign fa8_sum   = fa8_a ^ fa8_b ^ fa8_cin;
  assign fa8_carry = (fa8_a & fa8_b) | (fa8_cin & (fa8_a | fa8_b));
  assign fa1_sum   = fa1_a ^ fa1_b ^ fa1_cin;
  assign fa1_carry = (fa1_a & fa1_b) | (fa1_cin & (fa1_a | fa1_b));

  serial_add_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8),
    .a(a8), .b(b8), .cin(cin8),
    .ready(ready8), .busy(busy8), .done(done8),
    .sum(sum8), .cout(cout8),
    .fa_a(fa8_a), .fa_b(fa8_b), .fa_cin(fa8_cin),
    .fa_sum(fa8_sum), .fa_carry(fa8_carry)
  );

  serial_add_ctrl #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .a(a1), .b(b1), .cin(cin1),
    .ready(ready1), .busy(busy1), .done(done1),
    .sum(sum1), .cout(cout1),
    .fa_a(fa1_a), .fa_b(fa1_b), .fa_cin(fa1_cin),
    .fa_sum(fa1_sum), .fa_carry(fa1_carry)
  );

  int n_chk = 0;
  int n_err = 0;
  logic [8:0] held8 = '0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b,
                     input logic c, input bit hold, input int glitch,
                     output int acc_cyc);
    logic [8:0] full;
    int m, ci;
    full = 9'(a) + 9'(b) + 9'(c);
    chk("ready_pre", 64'(ready8), 64'd1);
    start8 = 1'b1; a8 = a; b8 = b; cin8 = c;
    @(posedge clk);
    @(negedge clk);
    acc_cyc = cyc;
    for (int i = 0; i < 8; i++) begin
      m  = (1 << i) - 1;
      ci = ((int'(a) & m) + (int'(b) & m) + int'(c)) >> i;
      chk("run_busy", 64'(busy8), 64'd1);
      chk("run_done", 64'(done8), 64'd0);
      chk("run_ready", 64'(ready8), 64'd0);
      chk("fa_a", 64'(fa8_a), 64'(a[i]));
      chk("fa_b", 64'(fa8_b), 64'(b[i]));
      chk("fa_cin", 64'(fa8_cin), 64'(ci & 1));
      chk("sum_held", 64'({cout8, sum8}), 64'(held8));
      if (i == glitch) begin
        start8 = 1'b1; a8 = 8'h00; b8 = 8'h00;
      end else begin
        if (!hold) start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom);
        cin8 = 1'($urandom);
      end
      step();
    end
    chk("done_hi", 64'(done8), 64'd1);
    chk("done_busy", 64'(busy8), 64'd0);
    chk("done_ready", 64'(ready8), 64'd0);
    chk("sum", 64'(sum8), 64'(full[7:0]));
    chk("cout", 64'(cout8), 64'(full[8]));
    chk("done_fa", 64'({fa8_a, fa8_b, fa8_cin}), 64'd0);
    held8 = full;
    if (!hold) start8 = 1'b0;
    step();
    chk("done_pulse", 64'(done8), 64'd0);
    chk("idle_ready", 64'(ready8), 64'd1);
    chk("idle_busy", 64'(busy8), 64'd0);
    chk("idle_sum", 64'({cout8, sum8}), 64'(held8));
    chk("idle_fa", 64'({fa8_a, fa8_b, fa8_cin}), 64'd0);
  endtask

  task automatic op1(input logic a, input logic b, input logic c);
    int full;
    full = int'(a) + int'(b) + int'(c);
    chk("w1_ready_pre", 64'(ready1), 64'd1);
    start1 = 1'b1; a1 = a; b1 = b; cin1 = c;
    step();
    start1 = 1'b0;
    a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
    chk("w1_busy", 64'(busy1), 64'd1);
    chk("w1_fa", 64'({fa1_a, fa1_b, fa1_cin}), 64'({a, b, c}));
    chk("w1_early_done", 64'(done1), 64'd0);
    step();
    chk("w1_done", 64'(done1), 64'd1);
    chk("w1_result", 64'({cout1, sum1}), 64'(full));
    step();
    chk("w1_idle", 64'({ready1, done1, busy1}), 64'b100);
  endtask

  initial begin
    int acc0, acc1, acc2;
    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    step();
    step();
    chk("rst8_flags", 64'({ready8, busy8, done8}), 64'b100);
    chk("rst8_res", 64'({cout8, sum8}), 64'd0);
    chk("rst8_fa", 64'({fa8_a, fa8_b, fa8_cin}), 64'd0);
    chk("rst1_flags", 64'({ready1, busy1, done1}), 64'b100);
    chk("rst1_res", 64'({cout1, sum1, fa1_a, fa1_b, fa1_cin}), 64'd0);
    rst_n = 1'b1;
    step();

    op8(8'h5A, 8'h33, 1'b0, 1'b0, -1, acc0);
    op8(8'hFF, 8'h01, 1'b0, 1'b0, -1, acc0);
    op8(8'hFF, 8'hFF, 1'b1, 1'b0, -1, acc0);

    for (int k = 0; k < 8; k++) begin
      op1(1'((k >> 2) & 1), 1'((k >> 1) & 1), 1'(k & 1));
    end

    op8(8'h10, 8'h20, 1'b0, 1'b0, 2, acc0);

    start8 = 1'b1; a8 = 8'h44; b8 = 8'h11; cin8 = 1'b0;
    step();
    start8 = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    held8 = '0;
    chk("mid_rst_flags", 64'({ready8, busy8, done8}), 64'b100);
    chk("mid_rst_res", 64'({cout8, sum8}), 64'd0);
    chk("mid_rst_fa", 64'({fa8_a, fa8_b, fa8_cin}), 64'd0);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("mid_rst_nodone", 64'({ready8, done8}), 64'b10);
    end
    op8(8'h01, 8'h02, 1'b0, 1'b0, -1, acc0);

    op8(8'($urandom), 8'($urandom), 1'($urandom), 1'b1, -1, acc0);
    op8(8'($urandom), 8'($urandom), 1'($urandom), 1'b1, -1, acc1);
    op8(8'($urandom), 8'($urandom), 1'($urandom), 1'b1, -1, acc2);
    start8 = 1'b0;
    chk("b2b_gap1", 64'(acc1 - acc0), 64'd10);
    chk("b2b_gap2", 64'(acc2 - acc1), 64'd10);
    step();

    for (int k = 0; k < 20; k++) begin
      op8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, -1, acc0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
